multicycle_core: RTL and testbench
==================================

// Module: multicycle_core
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle 3BC top level, with a sequencing FSM replacing single-cycle control.
//  Fetches 9-bit instructions from an external sync ROM and runs a 4-entry register file plus ALU.
//  Accesses data memory through a variable-latency req/ack port. Start/Ack program handshake is unchanged.
// PARAMETERS
//  DW   8   data/register width (>=3)
//  PCW  10  program counter / InstAddr width
//  AW   8   data memory address width
// PORTS
//  Clk       in   1    clock, posedge
//  Reset     in   1    synchronous, active-high
//  Start     in   1    begin next program (level; sampled in IDLE/DONE only)
//  Ack       out  1    program done (HALT executed)
//  InstAddr  out  PCW  ROM address; InstIn valid 1 cycle later
//  InstIn    in   9    instruction {op[8:5],ra[4:3],rb[2:1]}; imm = [2:0]
//  MemReq    out  1    data memory request, held until MemAck
//  MemWe     out  1    1=store, 0=load; valid while MemReq
//  MemAddr   out  AW   R[rb] zero-extended/truncated to AW
//  MemWdata  out  DW   R[ra] for store
//  MemRdata  in   DW   load data, valid with MemAck
//  MemAck    in   1    completes request; ignored unless MemReq=1
//  CycleCt   out  32   busy cycle count (see CONFIGURATION)
//  InstrCt   out  32   retired instruction count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, PC=0, R0..R3=0, Ack=0, MemReq=0, MemWe=0, counters=0. Reset wins over all events, incl. mid-MEM.
//  FSM: IDLE -Start-> FETCH -> EXEC -> {FETCH | MEM | DONE}; MEM -MemAck-> FETCH; DONE -Start-> FETCH.
//  FETCH: InstAddr=PC (1 cycle). EXEC: decode InstIn, update regs/PC at end of cycle.
//  ALU/branch instr = 2 cycles; LD/ST = 3 + wait cycles. MemAck in first MEM cycle = zero-wait.
//  Opcodes (all arithmetic mod 2^DW):
//   0 ADD ra+=rb | 1 SUB ra-=rb | 2 AND | 3 OR | 4 XOR | 5 SHL ra<<=imm | 6 SHR (logical) ra>>=imm
//   7 LDI ra=zext(imm) | 8 LD ra=mem[R[rb]] | 9 ST mem[R[rb]]=R[ra] | 10 BNZ | 11 MOV ra=rb
//   15 HALT | 12-14 NOP
//  PC: +1 mod 2^PCW after each non-taken instr; HALT also advances PC, so next Start runs the following program.
//  BNZ: if R[ra]!=0 then PC = PC_of_BNZ + sext(R[rb]) mod 2^PCW (truncate if DW>PCW), else PC+1.
//  MEM: MemReq/MemWe/MemAddr/MemWdata registered and stable until ack cycle.
//   LD writes MemRdata to ra on the ack edge. MemReq drops the cycle after ack.
//  Ack: registered; 1 from the cycle after HALT's EXEC until the cycle after Start is sampled in DONE.
//  Start: ignored in FETCH/EXEC/MEM. No register write occurs outside EXEC/MEM-ack.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   CycleCt +1 every cycle in FETCH/EXEC/MEM; cleared on Start from IDLE/DONE; frozen in DONE.
//   InstrCt +1 per retired instruction, HALT included; cleared with CycleCt.
//   Counters wrap at 2^32.
//  PERF_CNT_EN undefined: CycleCt=InstrCt=0 constant; no counter flops.
// TESTING
//  1 Reset, Start, prog LDI R1,5;LDI R2,3;ADD R1,R2;ST R1,[R2];HALT
//    -> MemReq,MemWe=1,MemAddr=3,MemWdata=8; Ack=1; CycleCt=11, InstrCt=5
//  2 R2=4; LD R1,[R2] with MemAck delayed 3 cycles
//    -> MemReq high 4 cycles, MemAddr=4, R1 unchanged until ack edge, then =MemRdata
//  3 LDI R1,3;LDI R2,1;LDI R3,0;SUB R3,R2;SUB R1,R2;BNZ R1,R3;HALT
//    -> InstAddr of SUB R1,R2 repeats 3x, R1=0, Ack=1, InstrCt=11
//  4 Pulse Start mid-program -> no effect. Start in DONE
//    -> Ack=0 next cycle, fetch resumes at HALT addr+1
//  5 Reset asserted while MemReq=1 awaiting ack
//    -> next cycle MemReq=0, Ack=0, InstAddr=0, regs=0; stale MemAck ignored
//  6 Build without PERF_CNT_EN, rerun test 1 -> identical Ack/memory trace; CycleCt=InstrCt=0 throughout

Source files
------------

// File: rtl/multicycle_core.sv
// Multi-cycle 3BC core: FSM-sequenced fetch/execute over a sync instruction ROM and a req/ack data port.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module multicycle_core #(
    parameter int DW  = 8,
    parameter int PCW = 10,
    parameter int AW  = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    output logic           Ack,
    output logic [PCW-1:0] InstAddr,
    input  logic [8:0]     InstIn,
    output logic           MemReq,
    output logic           MemWe,
    output logic [AW-1:0]  MemAddr,
    output logic [DW-1:0]  MemWdata,
    input  logic [DW-1:0]  MemRdata,
    input  logic           MemAck,
    output logic [31:0]    CycleCt,
    output logic [31:0]    InstrCt
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_BNZ  = 4'd10;
    localparam logic [3:0] OP_MOV  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_DONE
    } state_t;

    state_t                 state;
    logic [PCW-1:0]         pc;
    logic [DW-1:0]          rf [4];
    logic [1:0]             ld_dest;

    logic [3:0]             op;
    logic [1:0]             ra;
    logic [1:0]             rb;
    logic [2:0]             imm;
    logic [DW-1:0]          a;
    logic [DW-1:0]          b;
    logic signed [DW-1:0]   b_s;
    logic signed [PCW-1:0]  br_off;
    logic [DW-1:0]          alu;
    logic                   writes_reg;
    logic                   is_mem;
    logic [PCW-1:0]         pc_next;

    assign op  = InstIn[8:5];
    assign ra  = InstIn[4:3];
    assign rb  = InstIn[2:1];
    assign imm = InstIn[2:0];
    assign a   = rf[ra];
    assign b   = rf[rb];
    assign b_s = b;

    // Branch offset is R[rb] sign-extended, or truncated when DW exceeds PCW.
    assign br_off  = PCW'(b_s);
    assign pc_next = pc + PCW'(1);

    assign writes_reg = (op <= OP_LDI) || (op == OP_MOV);
    assign is_mem     = (op == OP_LD) || (op == OP_ST);
    assign InstAddr   = pc;

    always_comb begin
        alu = a;
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_SHL:  alu = a << imm;
            OP_SHR:  alu = a >> imm;
            OP_LDI:  alu = DW'(imm);
            OP_MOV:  alu = b;
            default: alu = a;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= S_IDLE;
            pc     <= '0;
            Ack    <= 1'b0;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    pc    <= pc_next;
                    state <= S_FETCH;
                    if (writes_reg) rf[ra] <= alu;
                    if (is_mem) begin
                        MemReq <= 1'b1;
                        MemWe  <= (op == OP_ST);
                        state  <= S_MEM;
                    end
                    if (op == OP_BNZ && a != '0) pc <= pc + $unsigned(br_off);
                    if (op == OP_HALT) begin
                        Ack   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_MEM: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                        if (!MemWe) rf[ld_dest] <= MemRdata;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (Start) begin
                        Ack   <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request payload is captured once at EXEC and held untouched until the ack.
    always_ff @(posedge Clk) begin
        if (state == S_EXEC && is_mem) begin
            MemAddr  <= AW'(b);
            MemWdata <= a;
            ld_dest  <= ra;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cycle_ct;
    logic [31:0] instr_ct;
    logic        busy;
    logic        retire;
    logic        launch;

    assign busy   = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign retire = (state == S_EXEC && !is_mem) || (state == S_MEM && MemAck);
    assign launch = (state == S_IDLE || state == S_DONE) && Start;

    always_ff @(posedge Clk) begin
        if (Reset || launch) begin
            cycle_ct <= '0;
            instr_ct <= '0;
        end else if (busy) begin
            cycle_ct <= cycle_ct + 32'd1;
            if (retire) instr_ct <= instr_ct + 32'd1;
        end
    end

    assign CycleCt = cycle_ct;
    assign InstrCt = instr_ct;
`else
    assign CycleCt = '0;
    assign InstrCt = '0;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: ROM model, scoreboarded data-memory responder, program-level checks.
module tb_multicycle_core;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Ack;
    logic [9:0]  InstAddr;
    logic [8:0]  InstIn;
    logic        MemReq;
    logic        MemWe;
    logic [7:0]  MemAddr;
    logic [7:0]  MemWdata;
    logic [7:0]  MemRdata;
    logic        MemAck;
    logic [31:0] CycleCt;
    logic [31:0] InstrCt;

    multicycle_core #(.DW(8), .PCW(10), .AW(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .InstAddr(InstAddr), .InstIn(InstIn),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWdata(MemWdata), .MemRdata(MemRdata), .MemAck(MemAck),
        .CycleCt(CycleCt), .InstrCt(InstrCt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    logic [8:0] rom [0:63];
    always @(posedge Clk) InstIn <= rom[InstAddr[5:0]];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         delay;
    } mem_t;

    mem_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_ct = 0;
    int   watch_addr = -1;
    int   watch_hits = 0;
    int   prev_addr = -1;

    function automatic logic [8:0] ri(input int op, input int ra, input int rb);
        return {op[3:0], ra[1:0], rb[1:0], 1'b0};
    endfunction

    function automatic logic [8:0] im(input int op, input int ra, input int imm);
        return {op[3:0], ra[1:0], imm[2:0]};
    endfunction

    function automatic logic [31:0] exp_ct(input int v);
`ifdef PERF_CNT_EN
        return v;
`else
        return (v == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // One clock: at the falling edge, act as the data memory and track fetch addresses.
    task automatic step();
        mem_t cur;
        @(negedge Clk);
        MemAck = 1'b0;
        if (MemReq) begin
            if (sb.size() == 0) begin
                chk("unexpected_req", {31'd0, MemReq}, 32'd0);
            end else begin
                cur = sb[0];
                chk("mem_we", {31'd0, MemWe}, {31'd0, cur.we});
                chk("mem_addr", {24'd0, MemAddr}, {24'd0, cur.addr});
                if (cur.we) chk("mem_wdata", {24'd0, MemWdata}, {24'd0, cur.wdata});
                if (wait_ct == cur.delay) begin
                    MemAck   = 1'b1;
                    MemRdata = cur.rdata;
                    void'(sb.pop_front());
                    wait_ct = 0;
                end else begin
                    wait_ct++;
                end
            end
        end else begin
            wait_ct = 0;
        end
        if (int'(InstAddr) == watch_addr && prev_addr != watch_addr) watch_hits++;
        prev_addr = int'(InstAddr);
    endtask

    task automatic launch();
        step();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic wait_done(input int mid, input int budget);
        int n;
        n = 0;
        while (!Ack && n < budget) begin
            step();
            Start = (n == mid);
            n++;
        end
        Start = 1'b0;
        chk("done_ack", {31'd0, Ack}, 32'd1);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        MemAck = 1'b0;
        MemRdata = 8'd0;
        for (int i = 0; i < 64; i++) rom[i] = ri(15, 0, 0);
        rom[0]  = im(7, 1, 5);  rom[1]  = im(7, 2, 3);  rom[2]  = ri(0, 1, 2);
        rom[3]  = ri(9, 1, 2);  rom[4]  = ri(15, 0, 0);
        rom[5]  = im(7, 2, 4);  rom[6]  = ri(8, 1, 2);  rom[7]  = ri(9, 1, 2);
        rom[8]  = ri(15, 0, 0);
        rom[9]  = im(7, 1, 3);  rom[10] = im(7, 2, 1);  rom[11] = im(7, 3, 0);
        rom[12] = ri(1, 3, 2);  rom[13] = ri(1, 1, 2);  rom[14] = ri(10, 1, 3);
        rom[15] = ri(15, 0, 0);
        rom[16] = ri(9, 1, 0);  rom[17] = ri(15, 0, 0);
        rom[18] = im(7, 3, 7);  rom[19] = ri(8, 0, 3);  rom[20] = ri(15, 0, 0);

        repeat (3) step();
        Reset = 1'b0;
        chk("rst_ack", {31'd0, Ack}, 32'd0);
        chk("rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("rst_memwe", {31'd0, MemWe}, 32'd0);
        chk("rst_instaddr", {22'd0, InstAddr}, 32'd0);
        chk("rst_cyclect", CycleCt, 32'd0);
        chk("rst_instrct", InstrCt, 32'd0);

        // Program 1: arithmetic then a zero-wait store of 8 to address 3.
        sb.push_back('{1'b1, 8'd3, 8'd8, 8'd0, 0});
        launch();
        wait_done(-1, 100);
        chk("p1_cyclect", CycleCt, exp_ct(11));
        chk("p1_instrct", InstrCt, exp_ct(5));
        chk("p1_sb_left", sb.size(), 32'd0);
        repeat (3) step();
        chk("p1_frozen_cyc", CycleCt, exp_ct(11));
        chk("p1_ack_hold", {31'd0, Ack}, 32'd1);

        // Program 2: load with three wait states, then store the loaded value back.
        sb.push_back('{1'b0, 8'd4, 8'd0, 8'hA5, 3});
        sb.push_back('{1'b1, 8'd4, 8'hA5, 8'd0, 3});
        launch();
        wait_done(-1, 100);
        chk("p2_cyclect", CycleCt, exp_ct(16));
        chk("p2_instrct", InstrCt, exp_ct(4));
        chk("p2_sb_left", sb.size(), 32'd0);

        // Program 3: countdown loop, with a stray Start pulse mid-run.
        watch_addr = 13;
        watch_hits = 0;
        launch();
        wait_done(5, 100);
        chk("p3_loop_hits", watch_hits, 32'd3);
        chk("p3_cyclect", CycleCt, exp_ct(22));
        chk("p3_instrct", InstrCt, exp_ct(11));
        watch_addr = -1;

        // Program 4: resumes after the previous HALT and stores R1 (now 0) to address R0.
        sb.push_back('{1'b1, 8'd0, 8'd0, 8'd0, 0});
        launch();
        chk("p4_ack_clr", {31'd0, Ack}, 32'd0);
        chk("p4_resume_pc", {22'd0, InstAddr}, 32'd16);
        wait_done(-1, 100);
        chk("p4_cyclect", CycleCt, exp_ct(5));
        chk("p4_instrct", InstrCt, exp_ct(2));
        chk("p4_sb_left", sb.size(), 32'd0);

        // Program 5: reset lands while a load waits for an ack that never comes.
        sb.push_back('{1'b0, 8'd7, 8'd0, 8'h3C, 1000});
        launch();
        for (int n = 0; n < 20 && !MemReq; n++) step();
        chk("p5_req_seen", {31'd0, MemReq}, 32'd1);
        repeat (2) step();
        Reset = 1'b1;
        step();
        chk("p5_rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("p5_rst_ack", {31'd0, Ack}, 32'd0);
        chk("p5_rst_instaddr", {22'd0, InstAddr}, 32'd0);
        chk("p5_rst_cyc", CycleCt, 32'd0);
        chk("p5_rst_r0", {24'd0, dut.rf[0]}, 32'd0);
        chk("p5_rst_r1", {24'd0, dut.rf[1]}, 32'd0);
        chk("p5_rst_r2", {24'd0, dut.rf[2]}, 32'd0);
        chk("p5_rst_r3", {24'd0, dut.rf[3]}, 32'd0);
        Reset = 1'b0;
        sb.delete();
        step();
        MemAck = 1'b1;
        step();
        chk("p5_stale_memreq", {31'd0, MemReq}, 32'd0);
        chk("p5_stale_pc", {22'd0, InstAddr}, 32'd0);
        chk("p5_stale_r0", {24'd0, dut.rf[0]}, 32'd0);

        // Program 1 again from a clean reset: same memory trace and counts.
        sb.push_back('{1'b1, 8'd3, 8'd8, 8'd0, 0});
        launch();
        wait_done(-1, 100);
        chk("p6_cyclect", CycleCt, exp_ct(11));
        chk("p6_instrct", InstrCt, exp_ct(5));
        chk("p6_sb_left", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
